// File: rtl/expr_eval_share_arb_if.sv
// Request / datapath / response bundle for expr_eval_share_arb.
// slave: the arbiter side. master: requesters, datapath and response consumer.
// Optional parity signals exist only when EXPR_ARB_PARITY_EN is defined.
interface expr_eval_share_arb_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned OPW  = 60,
  parameter int unsigned RESW = 90,
  parameter int unsigned IDW  = $clog2(NREQ)
) ();
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*OPW-1:0] req_operands;
  logic [OPW-1:0]      dp_operands;
  logic [RESW-1:0]     dp_result;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [RESW-1:0]     rsp_data;
  logic                busy;
`ifdef EXPR_ARB_PARITY_EN
  logic                dp_parity;
  logic                rsp_parity;
  logic                parity_err;

  modport slave (
    input  req_valid, req_operands, dp_result, rsp_ready, dp_parity,
    output req_ready, dp_operands, rsp_valid, rsp_id, rsp_data, busy, rsp_parity, parity_err
  );
  modport master (
    output req_valid, req_operands, dp_result, rsp_ready, dp_parity,
    input  req_ready, dp_operands, rsp_valid, rsp_id, rsp_data, busy, rsp_parity, parity_err
  );
`else
  modport slave (
    input  req_valid, req_operands, dp_result, rsp_ready,
    output req_ready, dp_operands, rsp_valid, rsp_id, rsp_data, busy
  );
  modport master (
    output req_valid, req_operands, dp_result, rsp_ready,
    input  req_ready, dp_operands, rsp_valid, rsp_id, rsp_data, busy
  );
`endif
endinterface

// File: rtl/expr_eval_share_arb.sv
// Round-robin share of one combinational expression datapath between NREQ requesters.
// One transaction in flight: IDLE (arbitrate) -> WAIT (hold operands) -> RESP (valid/ready).
// Optional feature macro: EXPR_ARB_PARITY_EN adds rsp_parity, dp_parity and sticky parity_err.
module expr_eval_share_arb #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned OPW      = 60,
  parameter int unsigned RESW     = 90,
  parameter int unsigned EVAL_LAT = 2,
  parameter int unsigned IDW      = $clog2(NREQ)
) (
  input logic                  clk,
  input logic                  rst,
  expr_eval_share_arb_if.slave bus
);

  localparam int unsigned CntW = (EVAL_LAT > 1) ? $clog2(EVAL_LAT) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [RESW-1:0] rsp_data_q, rsp_data_d;
`ifdef EXPR_ARB_PARITY_EN
  logic            rsp_parity_q, rsp_parity_d;
  logic            parity_err_q, parity_err_d;
`endif

  logic            grant_found;
  logic [IDW-1:0]  grant_id;
  logic [IDW-1:0]  scan_idx;
  logic [NREQ-1:0] req_ready;

  // Round-robin search starting at rr_ptr; first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = IDW'((int'(rr_ptr_q) + k) % NREQ);
      if (!grant_found && bus.req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_id    = scan_idx;
      end
    end
  end

  // Next-state and request-accept logic.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    req_ready   = '0;
`ifdef EXPR_ARB_PARITY_EN
    rsp_parity_d = rsp_parity_q;
    parity_err_d = parity_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          // Reset holds state in IDLE, so the accept strobe must be masked explicitly.
          req_ready = rst ? '0 : (NREQ'(1) << grant_id);
          op_d      = OPW'(bus.req_operands >> (32'(grant_id) * OPW));
          id_d      = grant_id;
          cnt_d     = CntW'(EVAL_LAT - 1);
          state_d   = StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          rsp_data_d  = bus.dp_result;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
`ifdef EXPR_ARB_PARITY_EN
          rsp_parity_d = ^bus.dp_result;
          if (bus.dp_parity != ^bus.dp_result) parity_err_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          // Pointer moves past the served requester only once its response is taken.
          rr_ptr_d    = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
`ifdef EXPR_ARB_PARITY_EN
      rsp_parity_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
`ifdef EXPR_ARB_PARITY_EN
      rsp_parity_q <= rsp_parity_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.dp_operands = op_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.busy        = (state_q != StIdle);
`ifdef EXPR_ARB_PARITY_EN
  assign bus.rsp_parity  = rsp_parity_q;
  assign bus.parity_err  = parity_err_q;
`endif

endmodule

// File: tb/tb_expr_eval_share_arb.sv
// Scoreboard bench for expr_eval_share_arb: stimulus pushes expected responses,
// a negedge monitor pops and compares on every response handshake.
module tb_expr_eval_share_arb;
  localparam int unsigned NREQ     = 4;
  localparam int unsigned OPW      = 60;
  localparam int unsigned RESW     = 90;
  localparam int unsigned EVAL_LAT = 2;
  localparam int unsigned IDW      = 2;

  typedef struct packed {
    logic [IDW-1:0]  id;
    logic [RESW-1:0] data;
  } exp_t;

  logic clk;
  logic rst;
  logic dp_corrupt;
`ifdef EXPR_ARB_PARITY_EN
  logic parity_flip;
`endif
  logic [OPW-1:0] ops [4];
  exp_t exp_q [$];
  exp_t mon_e;
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_gcyc = 0;
  int last_wait = 0;
  int prev;
  int seq [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 3, 0, 3};

  expr_eval_share_arb_if #(.NREQ(NREQ), .OPW(OPW), .RESW(RESW), .IDW(IDW)) bus ();

  expr_eval_share_arb #(
    .NREQ    (NREQ),
    .OPW     (OPW),
    .RESW    (RESW),
    .EVAL_LAT(EVAL_LAT),
    .IDW     (IDW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Datapath model: y = {sum(a_i*b_i) [30b], ~operands [60b]}.
  function automatic logic [RESW-1:0] dp_model(input logic [OPW-1:0] op);
    logic [29:0] s;
    s = '0;
    for (int i = 0; i < 6; i++) s = s + 30'(op[59-5*i -: 5]) * 30'(op[29-5*i -: 5]);
    return {s, ~op};
  endfunction

  assign bus.req_operands = {ops[3], ops[2], ops[1], ops[0]};
  assign bus.dp_result = dp_model(bus.dp_operands) ^ (dp_corrupt ? {RESW{1'b1}} : {RESW{1'b0}});
`ifdef EXPR_ARB_PARITY_EN
  assign bus.dp_parity = (^bus.dp_result) ^ parity_flip;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Wait (bounded) for an accept, check it is the expected one-hot, optionally push expectation.
  task automatic expect_grant(input int exp_id, input bit push, input int max_wait);
    int w;
    logic [NREQ-1:0] oh;
    w = 0;
    oh = NREQ'(1) << exp_id;
    @(negedge clk);
    while (bus.req_ready == '0 && w < max_wait) begin
      @(negedge clk);
      w++;
    end
    check("grant", 128'(bus.req_ready), 128'(oh));
    if (push && bus.req_ready != '0)
      exp_q.push_back('{id: IDW'(exp_id), data: dp_model(ops[exp_id])});
    last_gcyc = cyc;
    last_wait = w;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_idle", 128'({bus.busy, exp_q.size() != 0}), 128'(0));
    @(posedge clk);
    #1;
  endtask

  // Response monitor.
  initial forever begin
    @(negedge clk);
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL rsp_unexpected: got id %0d data %0h, required no response",
                 bus.rsp_id, bus.rsp_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_id", 128'(bus.rsp_id), 128'(mon_e.id));
        check("rsp_data", 128'(bus.rsp_data), 128'(mon_e.data));
`ifdef EXPR_ARB_PARITY_EN
        check("rsp_parity", 128'(bus.rsp_parity), 128'(^mon_e.data));
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ops[0] = 60'h123456789ABCDEF;
    ops[1] = 60'hFEDCBA987654321;
    ops[2] = 60'h0F0F0F0F0F0F0F0;
    ops[3] = 60'hA5A5A5A5A5A5A5A;
    rst = 1'b1;
    dp_corrupt = 1'b0;
`ifdef EXPR_ARB_PARITY_EN
    parity_flip = 1'b0;
`endif
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;

    // Reset with all requests valid.
    repeat (3) begin
      @(negedge clk);
      check("rst_req_ready", 128'(bus.req_ready), 128'(0));
      check("rst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
      check("rst_busy", 128'(bus.busy), 128'(0));
      check("rst_dp_operands", 128'(bus.dp_operands), 128'(0));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_valid = '0;

    // Single request from requester 2, latency from accept edge.
    @(posedge clk); #1;
    bus.req_valid = 4'b0100;
    expect_grant(2, 1'b1, 5);
    prev = last_gcyc;
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    check("busy_wait", 128'(bus.busy), 128'(1));
    for (int n = 0; n < 20 && !bus.rsp_valid; n++) @(negedge clk);
    check("latency", 128'(cyc - (prev + 1)), 128'(EVAL_LAT));

    // Requester 3 makes the pointer wrap to 0; 1111 raised during WAIT is ignored.
    @(posedge clk); #1;
    bus.req_valid = 4'b1000;
    expect_grant(3, 1'b1, 10);
    @(posedge clk); #1;
    bus.req_valid = 4'b1111;

    // Fairness and minimum accept spacing.
    for (int k = 0; k < 12; k++) begin
      if (k == 8) begin
        @(posedge clk); #1;
        bus.req_valid = 4'b1001;
      end
      prev = last_gcyc;
      expect_grant(seq[k], 1'b1, 10);
      check("accept_spacing", 128'(last_gcyc - prev), 128'(EVAL_LAT + 2));
    end

    // Sole valid requester wins twice.
    @(posedge clk); #1;
    bus.req_valid = 4'b0010;
    expect_grant(1, 1'b1, 10);
    expect_grant(1, 1'b1, 10);
    @(posedge clk); #1;
    bus.req_valid = '0;
    drain();

    // Back-pressure: response stalls, datapath output is corrupted meanwhile.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0100;
    expect_grant(2, 1'b1, 5);
    @(posedge clk); #1;
    bus.req_valid = 4'b1111;
    for (int n = 0; n < 20 && !bus.rsp_valid; n++) @(negedge clk);
    @(posedge clk); #1;
    dp_corrupt = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_hold", {bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.req_ready},
            {1'b1, 2'd2, dp_model(ops[2]), 4'b0000});
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    dp_corrupt = 1'b0;
    expect_grant(3, 1'b1, 1);
    check("hs_to_accept", 128'(last_wait), 128'(1));
    @(posedge clk); #1;
    bus.req_valid = '0;
    drain();

    // Mid-flight reset: pointer first moved to 2, aborted transaction gives no response.
    bus.req_valid = 4'b0010;
    expect_grant(1, 1'b1, 5);
    @(posedge clk); #1;
    bus.req_valid = '0;
    drain();
    bus.req_valid = 4'b0100;
    expect_grant(2, 1'b0, 5);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req_valid = 4'b0110;
    @(posedge clk); #1;
    rst = 1'b0;
    expect_grant(1, 1'b1, 0);
    @(posedge clk); #1;
    bus.req_valid = '0;
    drain();

`ifdef EXPR_ARB_PARITY_EN
    check("parity_err_init", 128'(bus.parity_err), 128'(0));
    for (int t = 0; t < 3; t++) begin
      parity_flip = (t == 2);
      bus.req_valid = 4'b0001;
      expect_grant(0, 1'b1, 5);
      @(posedge clk); #1;
      bus.req_valid = '0;
      drain();
    end
    check("parity_err_set", 128'(bus.parity_err), 128'(1));
    parity_flip = 1'b0;
    bus.req_valid = 4'b0001;
    expect_grant(0, 1'b1, 5);
    @(posedge clk); #1;
    bus.req_valid = '0;
    drain();
    check("parity_err_sticky", 128'(bus.parity_err), 128'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("parity_err_rst", 128'(bus.parity_err), 128'(0));
`endif

    check("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
